// File: rtl/param_reg_arb_if.sv
// Handshake bundle between N requesters and the shared-register arbiter.
// The lock lines exist only when PARAM_REG_ARB_LOCK_EN is defined.
interface param_reg_arb_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] d_in;
`ifdef PARAM_REG_ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   ack;
    logic [W-1:0]   d_out;
    logic [IW-1:0]  owner;
    logic           upd;

`ifdef PARAM_REG_ARB_LOCK_EN
    modport master (output req, d_in, lock, input ack, d_out, owner, upd);
    modport slave  (input req, d_in, lock, output ack, d_out, owner, upd);
`else
    modport master (output req, d_in, input ack, d_out, owner, upd);
    modport slave  (input req, d_in, output ack, d_out, owner, upd);
`endif
endinterface

// File: rtl/param_reg_arb.sv
// Round-robin arbiter writing one winner's data per grant into a shared W-bit register.
// Define PARAM_REG_ARB_LOCK_EN to let a granted requester hold the grant for up to MAX_LOCK writes.
module param_reg_arb #(
    parameter int             W        = 8,
    parameter int             N        = 4,
    parameter logic [W-1:0]   RST_VAL  = '0,
    parameter int             MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           reset,
    param_reg_arb_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gid;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr_nxt;
    logic          found;
    logic          stay;
    logic [W-1:0]  sel_data;
`ifdef PARAM_REG_ARB_LOCK_EN
    logic [LW-1:0] lcnt;
`endif

    // Rotating priority: the first set request at or after ptr, wrapping past N-1.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = bus.d_in[int'(gid)*W +: W];
        ptr_nxt  = (int'(gid) == N-1) ? '0 : gid + 1'b1;
`ifdef PARAM_REG_ARB_LOCK_EN
        stay     = bus.lock[gid] && (int'(lcnt) < MAX_LOCK-1);
`else
        stay     = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gid       <= '0;
            bus.ack   <= '0;
            bus.d_out <= RST_VAL;
            bus.owner <= '0;
            bus.upd   <= 1'b0;
`ifdef PARAM_REG_ARB_LOCK_EN
            lcnt      <= '0;
`endif
        end else begin
            bus.upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gid     <= win;
                        bus.ack <= ONE << win;
                        state   <= GRANT;
                    end else begin
                        bus.ack <= '0;
                    end
                end
                GRANT: begin
                    if (bus.req[gid]) begin
                        bus.d_out <= sel_data;
                        bus.owner <= gid;
                        bus.upd   <= 1'b1;
                        // A locked winner keeps ack and ptr; otherwise move priority past it.
                        if (!stay) begin
                            bus.ack <= '0;
                            ptr     <= ptr_nxt;
                            state   <= IDLE;
                        end
`ifdef PARAM_REG_ARB_LOCK_EN
                        lcnt <= stay ? lcnt + 1'b1 : '0;
`endif
                    end else begin
                        bus.ack <= '0;
                        state   <= IDLE;
`ifdef PARAM_REG_ARB_LOCK_EN
                        lcnt    <= '0;
`endif
                    end
                end
                default: begin
                    bus.ack <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_reg_arb.sv
// Scoreboard bench for param_reg_arb: directed scenarios plus randomized requesters
// checked against a transaction-level round-robin model.
module tb_param_reg_arb;
    localparam int W        = 8;
    localparam int N        = 4;
    localparam int MAX_LOCK = 8;

    typedef struct {
        int owner;
        int data;
    } wr_t;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   lock;
    logic [N-1:0]   persist;
    bit             incr_data;

    param_reg_arb_if #(.W(W), .N(N)) bus ();
    assign bus.req  = req;
    assign bus.d_in = din;
`ifdef PARAM_REG_ARB_LOCK_EN
    assign bus.lock = lock;
`endif

    param_reg_arb #(.W(W), .N(N), .RST_VAL(8'h00), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Reference model: a grant is decided from a rotated view of the pending set,
    // the next search starts one past the last writer.
    wr_t          exp_q[$];
    int           log_own[$];
    int           log_dat[$];
    logic [N-1:0] exp_ack;
    logic [N-1:0] wrote;
    bit           m_busy;
    int           m_gid, m_ptr, m_run, m_last_d, m_last_o;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [2*N-1:0] dbl;
        dbl = {r, r} >> p;
        for (int k = 0; k < N; k++)
            if (dbl[k]) return (p + k) % N;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_run = 0;
            m_last_d = 0; m_last_o = 0;
            exp_ack = '0; wrote = '0;
            exp_q.delete();
        end else begin
            wrote = '0;
            if (!m_busy) begin
                if (req != '0) begin
                    m_gid  = rr_pick(req, m_ptr);
                    m_busy = 1;
                end
            end else if (req[m_gid]) begin
                m_last_d = int'(din[m_gid*W +: W]);
                m_last_o = m_gid;
                exp_q.push_back('{owner: m_gid, data: m_last_d});
                wrote[m_gid] = 1'b1;
                m_run++;
`ifdef PARAM_REG_ARB_LOCK_EN
                if (!(lock[m_gid] && m_run < MAX_LOCK)) begin
`else
                begin
`endif
                    m_busy = 0; m_run = 0;
                    m_ptr  = (m_gid + 1) % N;
                end
            end else begin
                m_busy = 0; m_run = 0;
            end
            exp_ack = m_busy ? (N'(1) << m_gid) : '0;
        end
    end

    // Monitor: every cycle compare ack, and pop one expected write per upd pulse.
    always @(negedge clk) begin
        if (!reset) begin
            check("ack", bus.ack, exp_ack);
            check("upd", bus.upd, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.upd) begin
                    check("owner", bus.owner, e.owner);
                    check("d_out", bus.d_out, e.data);
                    log_own.push_back(int'(bus.owner));
                    log_dat.push_back(int'(bus.d_out));
                end
            end
        end
    end

    task automatic drive_cycle(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (wrote[i]) begin
                if (exp_ack[i] || persist[i])
                    din[i*W +: W] = incr_data ? din[i*W +: W] + 1'b1 : W'($urandom);
                else begin
                    req[i] = 1'b0; lock[i] = 1'b0;
                end
            end else if (rnd && req[i] && exp_ack[i] && $urandom_range(0, 7) == 0) begin
                req[i] = 1'b0; lock[i] = 1'b0;
            end else if (rnd && !req[i] && $urandom_range(0, 2) == 0) begin
                req[i]        = 1'b1;
                din[i*W +: W] = W'($urandom);
                lock[i]       = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic clr_logs();
        log_own.delete();
        log_dat.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; din = '0; lock = '0; persist = '0; incr_data = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ack", bus.ack, 0);
        check("rst_dout", bus.d_out, 8'h00);
        check("rst_owner", bus.owner, 0);
        check("rst_upd", bus.upd, 0);
        @(negedge clk);
        reset = 1'b0;
        clr_logs();
    endtask

    initial begin
        int sv_d, sv_o;
        do_reset();

        // Single requester.
        req[2] = 1'b1; din[2*W +: W] = 8'hA5;
        repeat (6) drive_cycle(0);
        check("t1_cnt", log_own.size(), 1);
        check("t1_owner", log_own.size() > 0 ? log_own[0] : -1, 2);
        check("t1_data", log_dat.size() > 0 ? log_dat[0] : -1, 8'hA5);

        // All four at once, served in index order from ptr=0.
        do_reset();
        req = '1;
        for (int i = 0; i < N; i++) din[i*W +: W] = W'(8'h10 + i);
        repeat (20) drive_cycle(0);
        check("t2_cnt", log_own.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_owner", k < log_own.size() ? log_own[k] : -1, k);
            check("t2_data", k < log_dat.size() ? log_dat[k] : -1, 8'h10 + k);
        end

        // Grant 2, then 0 and 3 request continuously: they alternate starting at 3.
        req[2] = 1'b1; din[2*W +: W] = 8'h22;
        repeat (6) drive_cycle(0);
        clr_logs();
        req[0] = 1'b1; din[0 +: W] = 8'h40;
        req[3] = 1'b1; din[3*W +: W] = 8'h70;
        persist[0] = 1'b1; persist[3] = 1'b1;
        repeat (8) drive_cycle(0);
        persist = '0;
        repeat (20) drive_cycle(0);
        check("t3_cnt", log_own.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            check("t3_owner", k < log_own.size() ? log_own[k] : -1, (k % 2 == 0) ? 3 : 0);

        // Abort: requester 1 withdraws while acked.
        clr_logs();
        sv_d = m_last_d; sv_o = m_last_o;
        req[1] = 1'b1; din[W +: W] = 8'h5A;
        drive_cycle(0);
        req[1] = 1'b0;
        repeat (4) drive_cycle(0);
        check("t4_cnt", log_own.size(), 0);
        check("t4_dout", bus.d_out, sv_d);
        check("t4_owner", bus.owner, sv_o);

        // Async reset in the middle of a grant.
        req[2] = 1'b1; din[2*W +: W] = 8'h77;
        drive_cycle(0);
        #3;
        reset = 1'b1;
        #1;
        check("t5_ack", bus.ack, 0);
        check("t5_dout", bus.d_out, 8'h00);
        check("t5_upd", bus.upd, 0);
        req = 4'b1010; din[W +: W] = 8'h31; din[3*W +: W] = 8'h33;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clr_logs();
        repeat (12) drive_cycle(0);
        check("t5_first", log_own.size() > 0 ? log_own[0] : -1, 1);
        check("t5_second", log_own.size() > 1 ? log_own[1] : -1, 3);

        // Locked burst (or plain back-to-back writes without the lock feature).
        clr_logs();
        incr_data = 1;
        req[1] = 1'b1; lock[1] = 1'b1; din[W +: W] = 8'd1;
`ifdef PARAM_REG_ARB_LOCK_EN
        repeat (20) drive_cycle(0);
        check("t6_cnt", log_own.size(), 8);
        for (int k = 0; k < 8; k++)
            check("t6_data", k < log_dat.size() ? log_dat[k] : -1, k + 1);
`else
        persist[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) persist[1] = 1'b0;
            drive_cycle(0);
        end
        repeat (6) drive_cycle(0);
        check("t6_cnt", log_own.size(), 5);
        for (int k = 0; k < 5; k++)
            check("t6_data", k < log_dat.size() ? log_dat[k] : -1, k + 1);
`endif
        incr_data = 0;
        lock = '0;
        clr_logs();
        req = 4'b0101; din[0 +: W] = 8'h90; din[2*W +: W] = 8'h92;
        repeat (10) drive_cycle(0);
        check("t6_ptr", log_own.size() > 0 ? log_own[0] : -1, 2);

        // Randomized traffic.
        do_reset();
        repeat (1500) drive_cycle(1);
        repeat (80) drive_cycle(0);
        check("final_req_idle", req, 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
